// File: rtl/sub_bytes_serial_pkg.sv
// rtl/sub_bytes_serial_pkg.sv - shared AES widths, FSM state type and GF(2^8) helpers
package sub_bytes_serial_pkg;

    localparam int STATE_W = 128;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sb_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h01;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, x);
            x = gf_mul(x, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/inverse_sbox.sv
// rtl/inverse_sbox.sv - inverse AES S-box, combinational
module inverse_sbox
    import sub_bytes_serial_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = gf_inv(inv_affine(a));

endmodule

// File: rtl/sub_bytes_serial_sbox.sv
// rtl/sub_bytes_serial_sbox.sv - forward AES S-box, combinational
module sbox
    import sub_bytes_serial_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = fwd_affine(gf_inv(a));

endmodule

// File: rtl/sub_bytes_serial.sv
// rtl/sub_bytes_serial.sv - iterative AES SubBytes engine; SUB_BYTES_INV_EN adds the inv port and inverse S-boxes
module sub_bytes_serial
    import sub_bytes_serial_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SUB_BYTES_INV_EN
    input  logic               inv,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    localparam int NCHUNK  = 16 / BYTES_PER_CYCLE;
    localparam int CHUNK_W = BYTES_PER_CYCLE * BYTE_W;
    localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("sub_bytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sb_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [STATE_W-1:0] work_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [6:0]         base_bit;
    logic [CHUNK_W-1:0] chunk_in;
    logic [CHUNK_W-1:0] chunk_out;
`ifdef SUB_BYTES_INV_EN
    logic               inv_q;
`endif

    // Truncation to 7 bits is harmless: the largest chunk offset is 120
    assign base_bit = 7'(cnt_q) * 7'(CHUNK_W);
    assign chunk_in = work_q[base_bit +: CHUNK_W];

    genvar g;
    generate
        for (g = 0; g < BYTES_PER_CYCLE; g++) begin : g_box
            logic [7:0] fwd_b;
            sbox u_fwd (.a(chunk_in[g*BYTE_W +: BYTE_W]), .y(fwd_b));
`ifdef SUB_BYTES_INV_EN
            logic [7:0] inv_b;
            inverse_sbox u_inv (.a(chunk_in[g*BYTE_W +: BYTE_W]), .y(inv_b));
            assign chunk_out[g*BYTE_W +: BYTE_W] = inv_q ? inv_b : fwd_b;
`else
            assign chunk_out[g*BYTE_W +: BYTE_W] = fwd_b;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB_BYTES_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= in_state;
                        cnt_q      <= '0;
`ifdef SUB_BYTES_INV_EN
                        inv_q      <= inv;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    work_q[base_bit +: CHUNK_W] <= chunk_out;
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb/tb_sub_bytes_serial.sv - scoreboard bench for sub_bytes_serial at every legal BYTES_PER_CYCLE
module tb_sub_bytes_serial;

    localparam int NI = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
`ifdef SUB_BYTES_INV_EN
    logic         inv;
`endif
    logic         in_ready_v  [NI];
    logic         out_valid_v [NI];
    logic [127:0] out_state_v [NI];

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            sub_bytes_serial #(.BYTES_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
`ifdef SUB_BYTES_INV_EN
                .inv       (inv),
`endif
                .in_valid  (in_valid),
                .in_ready  (in_ready_v[g]),
                .in_state  (in_state),
                .out_valid (out_valid_v[g]),
                .out_ready (out_ready),
                .out_state (out_state_v[g])
            );
        end
    endgenerate

    int           n_vec = 0;
    int           n_miss = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    logic [127:0] exp_q [NI][$];
    logic [127:0] held  [NI];
    logic         pend  [NI];

    task automatic check(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d (B=%0d): got %h, expected %h", name, idx, 1 << idx, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic logic all_ready();
        for (int i = 0; i < NI; i++) if (!in_ready_v[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic all_valid();
        for (int i = 0; i < NI; i++) if (!out_valid_v[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic all_empty();
        for (int i = 0; i < NI; i++) if (exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && in_valid && all_ready()) acc_cyc = cyc;
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    pend[i] = 1'b0;
                end else if (out_valid_v[i]) begin
                    if (!pend[i]) begin
                        check("latency", i, 128'(cyc - acc_cyc), 128'((16 >> i) + 1));
                        held[i] = out_state_v[i];
                    end else begin
                        check("hold_stable", i, out_state_v[i], held[i]);
                    end
                    if (out_ready) begin
                        if (exp_q[i].size() == 0) fail_now($sformatf("unexpected_output dut%0d", i));
                        else check("data", i, out_state_v[i], exp_q[i].pop_front());
                        pend[i] = 1'b0;
                    end else begin
                        pend[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!all_ready() && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!all_ready()) fail_now("in_ready_timeout");
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!all_valid() && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!all_valid()) fail_now("out_valid_timeout");
    endtask

    task automatic send(input logic [127:0] state, input logic [127:0] exp, input logic push);
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_state = state;
        if (push) for (int i = 0; i < NI; i++) exp_q[i].push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (!all_empty() && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!all_empty()) fail_now({name, "_drain_timeout"});
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check({name, "_ready_after"}, i, 128'(in_ready_v[i]), 128'(1));
    endtask

    task automatic check_reset_vals(input string name);
        for (int i = 0; i < NI; i++) begin
            check({name, "_in_ready"}, i, 128'(in_ready_v[i]), 128'(1));
            check({name, "_out_valid"}, i, 128'(out_valid_v[i]), 128'(0));
            check({name, "_out_state"}, i, out_state_v[i], 128'h0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_state  = '0;
`ifdef SUB_BYTES_INV_EN
        inv       = 1'b0;
`endif
        for (int i = 0; i < NI; i++) begin
            pend[i] = 1'b0;
            held[i] = '0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("idle");

        send({16{8'h00}}, {16{8'h63}}, 1'b1);
        drain("zeros");
        send(128'hFFEEDDCCBBAA99887766554433221100, 128'h1628C14BEAACEEC4F533FC1BC3938263, 1'b1);
        drain("ramp");
        send(128'h0848f8e92a8dc69a2be2f4a0bee33d19, 128'h3052411ee55db4b8f198bfe0ae1127d4, 1'b1);
        drain("fips");

        // Backpressure: the result must sit still while extra in_valid pulses are refused
        out_ready = 1'b0;
        send({16{8'hCC}}, {16{8'h4B}}, 1'b1);
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < NI; i++) check("bp_in_ready", i, 128'(in_ready_v[i]), 128'(0));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("backpressure");
        repeat (20) @(posedge clk);

        // Reset in the second BUSY cycle discards the in-flight state
        out_ready = 1'b0;
        send({16{8'h11}}, '0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send({16{8'h53}}, {16{8'hED}}, 1'b1);
        drain("after_reset");

`ifdef SUB_BYTES_INV_EN
        inv = 1'b1;
        send({16{8'h63}}, {16{8'h00}}, 1'b1);
        inv = 1'b0;
        drain("inv1");
        send({16{8'h63}}, {16{8'hFB}}, 1'b1);
        drain("inv0");
`endif

        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check("leftover_expected", i, 128'(exp_q[i].size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
